// File: rtl/sfm_pkg.sv
// Shared constants and helpers for the TCDM arbiter and its ID FIFO.
package sfm_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned MAX_OUTST_DEF = 4;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sfm_id_fifo.sv
// Channel-ID FIFO: remembers which channel owns each outstanding read.
module sfm_id_fifo
  import sfm_pkg::*;
#(
  parameter int unsigned DEPTH = MAX_OUTST_DEF,
  parameter int unsigned WIDTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [PW:0]                 count_q, count_d;
  logic                        do_push, do_pop;

  // DEPTH is a power of two, so the count MSB alone marks "full".
  assign full_o  = count_q[PW];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Next-state: pointers wrap naturally at DEPTH; simultaneous push/pop keeps the count.
  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sfm_tcdm_arbiter.sv
// N-to-1 TCDM arbiter: round-robin / fixed-priority select with stall lock,
// read-response routing via an in-order channel-ID FIFO.
module sfm_tcdm_arbiter
  import sfm_pkg::*;
#(
  parameter int unsigned NB_CHAN   = 4,
  parameter int unsigned DW        = DATA_W,
  parameter int unsigned AW        = 32,
  parameter int unsigned MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic                           prio_force_i,
  input  logic [$clog2(NB_CHAN)-1:0]     prio_i,
  input  logic [NB_CHAN-1:0]             ch_req_i,
  output logic [NB_CHAN-1:0]             ch_gnt_o,
  input  logic [NB_CHAN-1:0]             ch_wen_i,
  input  logic [NB_CHAN-1:0][AW-1:0]     ch_add_i,
  input  logic [NB_CHAN-1:0][DW/8-1:0]   ch_be_i,
  input  logic [NB_CHAN-1:0][DW-1:0]     ch_data_i,
  output logic [NB_CHAN-1:0]             ch_r_valid_o,
  output logic [NB_CHAN-1:0][DW-1:0]     ch_r_data_o,
  output logic                           out_req_o,
  output logic                           out_wen_o,
  output logic [AW-1:0]                  out_add_o,
  output logic [DW/8-1:0]                out_be_o,
  output logic [DW-1:0]                  out_data_o,
  input  logic                           out_gnt_i,
  input  logic                           out_r_valid_i,
  input  logic [DW-1:0]                  out_r_data_i,
  output logic [$clog2(MAX_OUTST):0]     outst_o,
  output logic                           err_o
);

  localparam int unsigned CW = idx_w(NB_CHAN);
  localparam logic [NB_CHAN-1:0] ONE_HOT0 = {{(NB_CHAN-1){1'b0}}, 1'b1};

  logic [NB_CHAN-1:0] elig;
  logic [CW-1:0]      sel, rr_idx, head_idx;
  logic [CW-1:0]      rr_q, rr_d, lock_idx_q, lock_idx_d;
  logic               lock_vld_q, lock_vld_d;
  logic               err_q, err_d;
  logic               rr_found, hs, push, pop, soft_rst;
  logic               fifo_full, fifo_empty;

  assign soft_rst = rst_i | clear_i;

  // Eligibility: reads are held off whenever the ID FIFO is full, even if it pops this cycle.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NB_CHAN; k++) begin
      elig[k] = ch_req_i[k] & (~ch_wen_i[k] | ~fifo_full);
    end
  end

  // Selection: a stalled (locked) channel wins, then the fixed-priority channel, then round-robin.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int i = 0; i < NB_CHAN; i++) begin
      if (!rr_found && elig[(int'(rr_q) + i) % NB_CHAN]) begin
        rr_found = 1'b1;
        rr_idx   = CW'((int'(rr_q) + i) % NB_CHAN);
      end
    end
    sel = rr_idx;
    if (prio_force_i && (int'(prio_i) < NB_CHAN) && elig[prio_i]) sel = prio_i;
    if (lock_vld_q && elig[lock_idx_q]) sel = lock_idx_q;
  end

  assign out_req_o  = |elig;
  assign hs         = out_req_o & out_gnt_i;
  assign out_wen_o  = ch_wen_i[sel];
  assign out_add_o  = ch_add_i[sel];
  assign out_be_o   = ch_be_i[sel];
  assign out_data_o = ch_data_i[sel];
  assign ch_gnt_o   = hs ? (ONE_HOT0 << sel) : '0;

  assign push         = hs & ch_wen_i[sel];
  assign pop          = out_r_valid_i & ~fifo_empty;
  assign ch_r_valid_o = pop ? (ONE_HOT0 << head_idx) : '0;
  assign err_o        = err_q;

  // Read data is broadcast; only the valid strobe is routed.
  always_comb begin
    for (int k = 0; k < NB_CHAN; k++) begin
      ch_r_data_o[k] = out_r_data_i;
    end
  end

  // Next-state: advance the pointer past the served channel, lock on a stall, latch stray responses.
  always_comb begin
    rr_d = rr_q;
    if (hs) rr_d = (sel == CW'(NB_CHAN - 1)) ? '0 : sel + 1'b1;
    lock_vld_d = out_req_o & ~out_gnt_i;
    lock_idx_d = lock_vld_d ? sel : lock_idx_q;
    err_d      = err_q | (out_r_valid_i & fifo_empty);
  end

  // State registers; soft clear behaves exactly like reset.
  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      rr_q       <= '0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  sfm_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (CW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (soft_rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (sel),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outst_o)
  );

endmodule

// File: tb/tb_sfm_tcdm_arbiter.sv
// Scoreboard bench for sfm_tcdm_arbiter: driver runs a queue-based reference
// model and posts expectations; a monitor on the falling edge checks them.
module tb_sfm_tcdm_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MO = 4;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1, clear_i = 1'b0, prio_force_i = 1'b0;
  logic [1:0]           prio_i = '0;
  logic [N-1:0]         ch_req_i = '0, ch_wen_i = '0;
  logic [N-1:0]         ch_gnt_o, ch_r_valid_o;
  logic [N-1:0][AW-1:0] ch_add_i = '0;
  logic [N-1:0][3:0]    ch_be_i = '0;
  logic [N-1:0][DW-1:0] ch_data_i = '0;
  logic [N-1:0][DW-1:0] ch_r_data_o;
  logic                 out_req_o, out_wen_o, out_gnt_i = 1'b0, out_r_valid_i = 1'b0;
  logic [AW-1:0]        out_add_o;
  logic [3:0]           out_be_o;
  logic [DW-1:0]        out_data_o, out_r_data_i = '0;
  logic [2:0]           outst_o;
  logic                 err_o;

  always #5 clk = ~clk;

  sfm_tcdm_arbiter #(.NB_CHAN(N), .DW(DW), .AW(AW), .MAX_OUTST(MO)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .prio_force_i(prio_force_i), .prio_i(prio_i),
    .ch_req_i(ch_req_i), .ch_gnt_o(ch_gnt_o), .ch_wen_i(ch_wen_i),
    .ch_add_i(ch_add_i), .ch_be_i(ch_be_i), .ch_data_i(ch_data_i),
    .ch_r_valid_o(ch_r_valid_o), .ch_r_data_o(ch_r_data_o),
    .out_req_o(out_req_o), .out_wen_o(out_wen_o), .out_add_o(out_add_o),
    .out_be_o(out_be_o), .out_data_o(out_data_o), .out_gnt_i(out_gnt_i),
    .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i),
    .outst_o(outst_o), .err_o(err_o)
  );

  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic          wen;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rv;
    int            outst;
    logic          err;
  } stat_t;

  typedef struct {
    int            ch;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] data;
    logic          wen;
  } gnt_t;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
  } rsp_t;

  stat_t stat_q[$];
  gnt_t  gnt_q[$];
  rsp_t  rsp_q[$];

  // Reference model state: pointer, locked channel (-1 = none), owners of outstanding reads, sticky error.
  int rr = 0;
  int lock = -1;
  int outq[$];
  bit m_err = 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit elig(input int k, input bit full);
    return ch_req_i[k] && (!ch_wen_i[k] || !full);
  endfunction

  // One clock cycle of stimulus plus the model's expectation for it.
  task automatic drive(input logic rst, input logic clr, input logic pf, input logic [1:0] pr,
                       input logic [N-1:0] rq, input logic [N-1:0] wn, input logic g,
                       input logic rv, input logic [DW-1:0] rd);
    stat_t s;
    gnt_t  ge;
    rsp_t  re;
    int    sel;
    bit    full;
    @(posedge clk);
    #1;
    rst_i = rst; clear_i = clr; prio_force_i = pf; prio_i = pr;
    ch_req_i = rq; ch_wen_i = wn; out_gnt_i = g; out_r_valid_i = rv; out_r_data_i = rd;
    for (int k = 0; k < N; k++) begin
      ch_add_i[k]  = $urandom;
      ch_be_i[k]   = 4'($urandom);
      ch_data_i[k] = $urandom;
    end
    full = (outq.size() >= MO);
    sel = -1;
    if (lock >= 0 && elig(lock, full)) sel = lock;
    if (sel < 0 && pf && elig(int'(pr), full)) sel = int'(pr);
    if (sel < 0) begin
      for (int i = 0; i < N; i++) begin
        if (sel < 0 && elig((rr + i) % N, full)) sel = (rr + i) % N;
      end
    end
    s.req   = (sel >= 0);
    s.addr  = s.req ? ch_add_i[sel] : '0;
    s.wen   = s.req ? ch_wen_i[sel] : 1'b0;
    s.gnt   = '0;
    s.rv    = '0;
    s.outst = outq.size();
    s.err   = m_err;
    if (s.req && g) begin
      s.gnt[sel] = 1'b1;
      ge.ch = sel; ge.addr = ch_add_i[sel]; ge.be = ch_be_i[sel];
      ge.data = ch_data_i[sel]; ge.wen = ch_wen_i[sel];
      gnt_q.push_back(ge);
    end
    if (rv) begin
      if (outq.size() > 0) begin
        re.ch = outq.pop_front();
        re.data = rd;
        s.rv[re.ch] = 1'b1;
        rsp_q.push_back(re);
      end else begin
        m_err = 1;
      end
    end
    if (s.req && g && ch_wen_i[sel]) outq.push_back(sel);
    if (s.req && g) rr = (sel + 1) % N;
    lock = (s.req && !g) ? sel : -1;
    if (rst || clr) begin
      rr = 0; lock = -1; outq.delete(); m_err = 0;
    end
    stat_q.push_back(s);
  endtask

  task automatic idle(input logic rst);
    drive(rst, 1'b0, 1'b0, 2'd0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: per-cycle status, then grant and response events as the DUT presents them.
  initial begin
    stat_t s;
    gnt_t  ge;
    rsp_t  re;
    forever begin
      @(negedge clk);
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        chk("out_req", out_req_o, s.req);
        if (s.req) begin
          chk("out_add", out_add_o, s.addr);
          chk("out_wen", out_wen_o, s.wen);
        end
        chk("ch_gnt", ch_gnt_o, s.gnt);
        chk("ch_r_valid", ch_r_valid_o, s.rv);
        chk("outst", outst_o, s.outst);
        chk("err", err_o, s.err);
      end
      if (ch_gnt_o != '0) begin
        if (gnt_q.size() == 0) chk("gnt_unexpected", ch_gnt_o, 0);
        else begin
          ge = gnt_q.pop_front();
          chk("gnt_ch", ch_gnt_o, 64'(1) << ge.ch);
          chk("gnt_add", out_add_o, ge.addr);
          chk("gnt_be", out_be_o, ge.be);
          chk("gnt_data", out_data_o, ge.data);
          chk("gnt_wen", out_wen_o, ge.wen);
        end
      end
      if (ch_r_valid_o != '0) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", ch_r_valid_o, 0);
        else begin
          re = rsp_q.pop_front();
          chk("rsp_ch", ch_r_valid_o, 64'(1) << re.ch);
          chk("rsp_data", ch_r_data_o[re.ch], re.data);
        end
      end
    end
  end

  initial begin
    idle(1'b1);
    idle(1'b1);

    // Round-robin rotation with all channels writing.
    repeat (5) drive(0, 0, 0, 2'd0, 4'hF, 4'h0, 1, 0, '0);

    // Fixed priority on channel 2, then channel 0 alone.
    idle(1'b1);
    repeat (4) drive(0, 0, 1, 2'd2, 4'b0101, 4'h0, 1, 0, '0);
    repeat (2) drive(0, 0, 1, 2'd2, 4'b0001, 4'h0, 1, 0, '0);

    // Stall lock on channel 1 while channel 0 joins.
    idle(1'b1);
    drive(0, 0, 0, 2'd0, 4'b0010, 4'h0, 0, 0, '0);
    drive(0, 0, 0, 2'd0, 4'b0011, 4'h0, 0, 0, '0);
    drive(0, 0, 0, 2'd0, 4'b0011, 4'h0, 0, 0, '0);
    drive(0, 0, 0, 2'd0, 4'b0011, 4'h0, 1, 0, '0);
    drive(0, 0, 0, 2'd0, 4'b0001, 4'h0, 1, 0, '0);

    // Fill the ID FIFO, then a read stalls while a write proceeds; full read held off even with a pop.
    idle(1'b1);
    repeat (4) drive(0, 0, 0, 2'd0, 4'b0001, 4'b0001, 1, 0, '0);
    drive(0, 0, 0, 2'd0, 4'b0011, 4'b0001, 1, 0, '0);
    drive(0, 0, 0, 2'd0, 4'b0001, 4'b0001, 1, 1, 32'h1111_0000);
    repeat (4) drive(0, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 1, $urandom);

    // In-order response routing to channels 3, 0, 2.
    idle(1'b1);
    drive(0, 0, 0, 2'd0, 4'b1000, 4'b1000, 1, 0, '0);
    drive(0, 0, 0, 2'd0, 4'b0001, 4'b0001, 1, 0, '0);
    drive(0, 0, 0, 2'd0, 4'b0100, 4'b0100, 1, 0, '0);
    drive(0, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 1, 32'hAAAA_AAAA);
    drive(0, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 1, 32'hBBBB_BBBB);
    drive(0, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 1, 32'hCCCC_CCCC);

    // Stray response sets the sticky error; reset clears it; a response right after reset is stray too.
    drive(0, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 1, 32'hDEAD_BEEF);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    drive(0, 0, 0, 2'd0, 4'b0001, 4'b0001, 1, 0, '0);
    drive(1, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 0, '0);
    drive(0, 0, 0, 2'd0, 4'b0000, 4'b0000, 0, 1, 32'h5555_5555);
    idle(1'b0);

    // Randomized traffic, with occasional soft clears.
    for (int c = 0; c < 3000; c++) begin
      drive(1'b0, ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
            2'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), $urandom);
    end

    idle(1'b0);
    idle(1'b0);
    @(negedge clk);
    #1;
    chk("stat_q_drained", stat_q.size(), 0);
    chk("gnt_q_drained", gnt_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
